// File: rtl/ysyx_22040127_lsu.sv
// Load/store unit pipeline stage.
// Holds one instruction at a time. Memory ops issue a single aligned request
// and, for loads, wait for one response. Non-memory ops and misaligned ops go
// straight to DONE. A flush either aborts the op or, if a load request has
// already been accepted by memory, drains its response before going idle.
module ysyx_22040127_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  // upstream
  input  logic                in_valid,
  output logic                in_allowin,
  input  logic                in_memread,
  input  logic                in_memwrite,
  input  logic [2:0]          in_memop,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [XLEN-1:0]     in_result,
  input  logic [RD_W-1:0]     in_rd,
  // downstream
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_misalign,
  // pipeline kill
  input  logic                flush,
  // memory request
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_we,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [XLEN-1:0]     req_wdata,
  output logic [XLEN/8-1:0]   req_wstrb,
  // memory response
  input  logic                rsp_valid,
  input  logic [XLEN-1:0]     rsp_data
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Access size in bytes; doubleword ops collapse to word on a 32-bit datapath.
  function automatic logic [3:0] op_size(input logic [2:0] op);
    logic [3:0] s;
    case (op[1:0])
      2'b00:   s = 4'd1;
      2'b01:   s = 4'd2;
      2'b10:   s = 4'd4;
      default: s = (XLEN == 64) ? 4'd8 : 4'd4;
    endcase
    return s;
  endfunction

  state_t              state_q, state_d;
  logic                memread_q, memread_d;
  logic                memwrite_q, memwrite_d;
  logic [2:0]          memop_q, memop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                misalign_q, misalign_d;

  // Alignment check on the incoming op, so misaligned ops never reach REQ.
  logic [3:0]          in_size;
  logic [OFF_W-1:0]    in_off;
  logic [OFF_W-1:0]    in_align_mask;
  logic                in_is_mem;
  logic                in_misalign;

  assign in_size       = op_size(in_memop);
  assign in_off        = in_addr[OFF_W-1:0];
  assign in_align_mask = OFF_W'(in_size - 4'd1);
  assign in_is_mem     = in_memread | in_memwrite;
  assign in_misalign   = in_is_mem && ((in_off & in_align_mask) != '0);

  // Lane placement for the captured op: strobe, bit mask and byte shift.
  logic [3:0]          cur_size;
  logic [OFF_W-1:0]    cur_off;
  logic [OFF_W+2:0]    byte_shift;
  logic [STRB_W-1:0]   base_strb;
  logic [XLEN-1:0]     lane_mask;

  assign cur_size   = op_size(memop_q);
  assign cur_off    = addr_q[OFF_W-1:0];
  assign byte_shift = {cur_off, 3'b000};
  assign base_strb  = STRB_W'((16'd1 << cur_size) - 16'd1);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane_mask
      assign lane_mask[gi*8 +: 8] = {8{base_strb[gi]}};
    end
  endgenerate

  // Load result: shift the addressed bytes down, then sign- or zero-extend.
  logic [XLEN-1:0]     ld_shifted;
  logic                ld_sign_bit;
  logic [XLEN-1:0]     ld_value;

  assign ld_shifted = rsp_data >> byte_shift;

  // Pick the sign bit of the loaded field.
  always_comb begin
    ld_sign_bit = 1'b0;
    case (cur_size)
      4'd1:    ld_sign_bit = ld_shifted[7];
      4'd2:    ld_sign_bit = ld_shifted[15];
      4'd4:    ld_sign_bit = ld_shifted[31];
      default: ld_sign_bit = ld_shifted[XLEN-1];
    endcase
  end

  assign ld_value = (ld_shifted & lane_mask) |
                    ((!memop_q[2] && ld_sign_bit) ? ~lane_mask : '0);

  // Handshake outputs. A flush blocks acceptance in the same cycle.
  assign in_allowin   = !flush && ((state_q == S_IDLE) ||
                                   ((state_q == S_DONE) && out_ready));
  assign out_valid    = (state_q == S_DONE);
  assign out_data     = data_q;
  assign out_rd       = rd_q;
  assign out_misalign = misalign_q;

  assign req_valid    = (state_q == S_REQ);
  assign req_we       = (state_q == S_REQ) && memwrite_q;
  assign req_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_wdata    = (wdata_q & lane_mask) << byte_shift;
  assign req_wstrb    = ((state_q == S_REQ) && memwrite_q) ? (base_strb << cur_off) : '0;

  // Next-state and capture logic.
  always_comb begin
    logic capture;
    capture    = 1'b0;
    state_d    = state_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memop_d    = memop_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    rd_d       = rd_q;
    misalign_d = misalign_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_allowin) capture = 1'b1;
      end
      S_REQ: begin
        if (flush) begin
          // An accepted load still owes a response; a store is finished.
          state_d = (req_ready && !memwrite_q) ? S_DRAIN : S_IDLE;
        end else if (req_ready) begin
          state_d = memwrite_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            data_d  = ld_value;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          state_d = S_IDLE;
          if (in_valid && in_allowin) capture = 1'b1;
        end
      end
      S_DRAIN: begin
        if (rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      memread_d  = in_memread;
      memwrite_d = in_memwrite;
      memop_d    = in_memop;
      addr_d     = in_addr;
      wdata_d    = in_wdata;
      rd_d       = in_rd;
      misalign_d = in_misalign;
      data_d     = in_misalign ? '0 : in_result;
      state_d    = (in_is_mem && !in_misalign) ? S_REQ : S_DONE;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memop_q    <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memop_q    <= memop_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_lsu.sv
// Directed testbench for ysyx_22040127_lsu: a 64-bit instance for most steps
// and a 32-bit instance for the narrow-datapath load cases.
module tb_ysyx_22040127_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus
  logic        in_memread, in_memwrite;
  logic [2:0]  in_memop;
  logic [31:0] in_addr;
  logic [4:0]  in_rd;
  logic        req_ready, rsp_valid, out_ready, flush;

  // 64-bit instance
  logic        in_valid, in_allowin;
  logic [63:0] in_wdata, in_result, rsp_data;
  logic        out_valid, out_misalign, req_valid, req_we;
  logic [63:0] out_data, req_wdata;
  logic [4:0]  out_rd;
  logic [31:0] req_addr;
  logic [7:0]  req_wstrb;

  // 32-bit instance
  logic        in_valid_n, in_allowin_n;
  logic [31:0] in_wdata_n, in_result_n, rsp_data_n;
  logic        out_valid_n, out_misalign_n, req_valid_n, req_we_n;
  logic [31:0] out_data_n, req_wdata_n;
  logic [4:0]  out_rd_n;
  logic [31:0] req_addr_n;
  logic [3:0]  req_wstrb_n;

  ysyx_22040127_lsu #(.XLEN(64), .ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_memop(in_memop), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_misalign(out_misalign), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  ysyx_22040127_lsu #(.XLEN(32), .ADDR_W(32), .RD_W(5)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_n), .in_allowin(in_allowin_n), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_memop(in_memop), .in_addr(in_addr),
    .in_wdata(in_wdata_n), .in_result(in_result_n), .in_rd(in_rd),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_rd(out_rd_n), .out_misalign(out_misalign_n), .flush(flush),
    .req_valid(req_valid_n), .req_ready(req_ready), .req_we(req_we_n),
    .req_addr(req_addr_n), .req_wdata(req_wdata_n), .req_wstrb(req_wstrb_n),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] op,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] result, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_memread  = rd_en;
    in_memwrite = wr_en;
    in_memop    = op;
    in_addr     = addr;
    in_wdata    = wdata;
    in_result   = result;
    in_rd       = rd;
  endtask

  task automatic load64(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] word, input logic [63:0] expd);
    drive(1'b1, 1'b0, op, addr, 64'h0, 64'h0, 5'd1);
    step();
    in_valid = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = word;
    step();
    rsp_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, expd);
    step();
    $display("load %s addr=0x%0h data=0x%0h", tag, addr, out_data);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_valid_n = 1'b0;
    in_memread = 1'b0; in_memwrite = 1'b0; in_memop = 3'b000;
    in_addr = '0; in_rd = '0;
    in_wdata = '0; in_result = '0; rsp_data = '0;
    in_wdata_n = '0; in_result_n = '0; rsp_data_n = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_allowin", in_allowin, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_we", req_we, 1'b0);
    chk("rst_req_wstrb", req_wstrb, 8'h00);
    chk("rst_misalign", out_misalign, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_rd", out_rd, 5'd0);
    $display("reset done");

    // lb at offset 3, sign-extended, latency 3
    drive(1'b1, 1'b0, 3'b000, 32'h1003, 64'h0, 64'h99, 5'd5);
    settle();
    chk("lb_allowin", in_allowin, 1'b1);
    step();
    in_valid = 1'b0;
    chk("lb_req_valid", req_valid, 1'b1);
    chk("lb_req_we", req_we, 1'b0);
    chk("lb_req_addr", req_addr, 32'h1000);
    chk("lb_out_valid_c1", out_valid, 1'b0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("lb_req_drop", req_valid, 1'b0);
    chk("lb_out_valid_c2", out_valid, 1'b0);
    rsp_valid = 1'b1;
    rsp_data  = 64'h0000_0000_80FF_0000;
    step();
    rsp_valid = 1'b0;
    chk("lb_out_valid_c3", out_valid, 1'b1);
    chk("lb_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_rd", out_rd, 5'd5);
    chk("lb_misalign", out_misalign, 1'b0);
    step();
    chk("lb_retire", out_valid, 1'b0);
    $display("lb addr=0x1003 data=0x%0h", out_data);

    // sh at offset 6
    drive(1'b0, 1'b1, 3'b001, 32'h2006, 64'hDEAD_BEEF_CAFE_1234, 64'h77, 5'd6);
    step();
    in_valid = 1'b0;
    chk("sh_req_valid", req_valid, 1'b1);
    chk("sh_req_we", req_we, 1'b1);
    chk("sh_wstrb", req_wstrb, 8'hC0);
    chk("sh_wdata", req_wdata, 64'h1234_0000_0000_0000);
    chk("sh_req_addr", req_addr, 32'h2000);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("sh_out_valid", out_valid, 1'b1);
    chk("sh_req_drop", req_valid, 1'b0);
    chk("sh_out_data", out_data, 64'h77);
    step();
    chk("sh_retire", out_valid, 1'b0);
    $display("sh addr=0x2006 wstrb=0xc0");

    // misaligned lw
    drive(1'b1, 1'b0, 3'b010, 32'h3002, 64'h0, 64'h55, 5'd7);
    step();
    in_valid = 1'b0;
    chk("mis_out_valid", out_valid, 1'b1);
    chk("mis_flag", out_misalign, 1'b1);
    chk("mis_data", out_data, 64'h0);
    chk("mis_req_valid", req_valid, 1'b0);
    chk("mis_rd", out_rd, 5'd7);
    step();
    chk("mis_retire", out_valid, 1'b0);
    chk("mis_req_valid2", req_valid, 1'b0);
    $display("lw addr=0x3002 misaligned");

    // misaligned sd
    drive(1'b0, 1'b1, 3'b011, 32'h7004, 64'h1, 64'h0, 5'd8);
    step();
    in_valid = 1'b0;
    chk("sd_mis_flag", out_misalign, 1'b1);
    chk("sd_mis_req", req_valid, 1'b0);
    step();
    $display("sd addr=0x7004 misaligned");

    // flush in WAIT, drained response
    drive(1'b1, 1'b0, 3'b010, 32'h4004, 64'h0, 64'h1, 5'd3);
    step();
    in_valid = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    chk("drain_allowin", in_allowin, 1'b0);
    chk("drain_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_hold_allowin", in_allowin, 1'b0);
      chk("drain_hold_valid", out_valid, 1'b0);
    end
    rsp_valid = 1'b1;
    rsp_data  = 64'hFFFF;
    step();
    rsp_valid = 1'b0;
    settle();
    chk("drain_exit_allowin", in_allowin, 1'b1);
    chk("drain_exit_valid", out_valid, 1'b0);
    $display("flush in wait drained");

    // backpressure in DONE
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 64'h0, 64'hA5A5, 5'd9);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 64'h0, 64'hBBBB, 5'd10);
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 64'hA5A5);
      chk("bp_rd", out_rd, 5'd9);
      chk("bp_allowin", in_allowin, 1'b0);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_allowin", in_allowin, 1'b1);
    step();
    chk("bp_next_data", out_data, 64'hBBBB);
    chk("bp_next_rd", out_rd, 5'd10);
    $display("backpressure held 5 cycles");

    // back-to-back ALU stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 3'b000, 32'h0, 64'h0, 64'h100 + 64'(i), 5'(i + 1));
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, 64'h100 + 64'(i));
      chk("stream_rd", out_rd, 5'(i + 1));
      $display("stream op %0d data=0x%0h", i, out_data);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", out_valid, 1'b0);

    // flush in REQ without req_ready
    drive(1'b1, 1'b0, 3'b000, 32'h5000, 64'h0, 64'h0, 5'd2);
    step();
    in_valid = 1'b0;
    chk("freq_req_valid", req_valid, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("freq_abort_req", req_valid, 1'b0);
    chk("freq_abort_valid", out_valid, 1'b0);
    settle();
    chk("freq_allowin", in_allowin, 1'b1);

    // flush together with new input
    drive(1'b0, 1'b0, 3'b000, 32'h0, 64'h0, 64'hCC, 5'd4);
    flush = 1'b1;
    settle();
    chk("fin_allowin", in_allowin, 1'b0);
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fin_not_taken", out_valid, 1'b0);
    $display("flush cases done");

    // load extension cases
    load64("ld",  3'b011, 32'h6000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    load64("lwu", 3'b110, 32'h6004, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF);
    load64("lh",  3'b001, 32'h600A, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    load64("lbu", 3'b100, 32'h6007, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_00F0);
    load64("lw",  3'b010, 32'h6004, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF);

    // 32-bit datapath: lhu at offset 2
    in_memread = 1'b1; in_memwrite = 1'b0; in_memop = 3'b101;
    in_addr = 32'h8002; in_rd = 5'd11; in_valid_n = 1'b1;
    step();
    in_valid_n = 1'b0;
    chk("n_lhu_req", req_valid_n, 1'b1);
    chk("n_lhu_addr", req_addr_n, 32'h8000);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data_n = 32'hABCD_0000;
    step();
    rsp_valid = 1'b0;
    chk("n_lhu_valid", out_valid_n, 1'b1);
    chk("n_lhu_data", out_data_n, 32'h0000_ABCD);
    chk("n_idle_64", out_valid, 1'b0);
    step();
    $display("xlen32 lhu data=0x%0h", out_data_n);

    // 32-bit datapath: op 011 acts as lw at a word-aligned address
    in_memop = 3'b011; in_addr = 32'h8004; in_rd = 5'd12; in_valid_n = 1'b1;
    step();
    in_valid_n = 1'b0;
    chk("n_ld_req", req_valid_n, 1'b1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data_n = 32'h8000_0001;
    step();
    rsp_valid = 1'b0;
    chk("n_ld_misalign", out_misalign_n, 1'b0);
    chk("n_ld_data", out_data_n, 32'h8000_0001);
    step();
    $display("xlen32 op011 data=0x%0h", out_data_n);

    // reset mid-transaction
    drive(1'b1, 1'b0, 3'b011, 32'h9000, 64'h0, 64'h0, 5'd13);
    step();
    in_valid = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", req_valid, 1'b0);
    chk("mrst_valid", out_valid, 1'b0);
    settle();
    chk("mrst_allowin", in_allowin, 1'b1);
    rsp_valid = 1'b1;
    rsp_data = 64'h1234;
    step();
    rsp_valid = 1'b0;
    chk("stray_rsp_ignored", out_valid, 1'b0);
    chk("stray_rsp_data", out_data, 64'h0);
    $display("reset mid-transaction done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_lsu.md
YSYX_22040127_LSU -- requirements
Module: ysyx_22040127_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter RD_W, default 5, destination register tag width.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); reset is synchronous and active-high, clock is clk.
REQ-005 SHALL have upstream ports: in_valid (in, 1); in_allowin (out, 1); in_memread (in, 1); in_memwrite (in, 1); in_memop (in, 3, 000 b/001 h/010 w/011 d/100 bu/101 hu/110 wu); in_addr (in, ADDR_W); in_wdata (in, XLEN, store data); in_result (in, XLEN, ALU result for non-memory ops); in_rd (in, RD_W).
REQ-006 SHALL have downstream ports: out_valid (out, 1); out_ready (in, 1, writeback allowin); out_data (out, XLEN, final writeback data); out_rd (out, RD_W); out_misalign (out, 1, address-misaligned flag).
REQ-007 SHALL have a flush port: flush (in, 1), which kills the instruction held in the stage.
REQ-008 SHALL have memory request ports: req_valid (out, 1); req_ready (in, 1); req_we (out, 1); req_addr (out, ADDR_W, aligned down to XLEN/8 bytes); req_wdata (out, XLEN); req_wstrb (out, XLEN/8).
REQ-009 SHALL have memory response ports: rsp_valid (in, 1) and rsp_data (in, XLEN, the full aligned word).

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-011 in_allowin SHALL be 1 only in IDLE, or in DONE when out_ready=1.
REQ-012 On in_valid&&in_allowin, SHALL capture all inputs. A memory op SHALL enter REQ; a non-memory op, or any misaligned op, SHALL enter DONE.
REQ-013 Access size SHALL be 1/2/4/8 bytes for b/h/w/d. An op is misaligned iff addr mod size != 0. A misaligned op SHALL set out_misalign=1, out_data=0, and issue no request.
REQ-014 When XLEN=32, ops 011 and 110 SHALL be treated as w (size 4, lw sign rule for 011, zero-extend for 110).
REQ-015 In REQ, req_valid SHALL be 1. On req_ready=1, go to WAIT; a store SHALL go directly to DONE, with no response expected.
REQ-016 req_wstrb SHALL be ((1<<size)-1) << off, where off = addr[log2(XLEN/8)-1:0].
REQ-017 req_wdata SHALL be the low size bytes of in_wdata shifted left by off*8.
REQ-018 In WAIT, on rsp_valid, SHALL latch (rsp_data >> off*8), truncated to size. It SHALL be sign-extended for b/h/w(/d) and zero-extended for bu/hu/wu, then the FSM SHALL go to DONE.
REQ-019 In DONE, out_valid SHALL be 1. out_data SHALL be the load result for loads and in_result otherwise. On out_ready=1, the FSM SHALL go to IDLE, or directly accept a new input (back-to-back).
REQ-020 out_valid SHALL be asserted only in DONE; outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Minimum load latency SHALL be 3 cycles (accept→REQ, req_ready→WAIT, rsp→DONE) with zero-wait memory. A non-memory op SHALL have 1 cycle latency.
REQ-022 Flush handling SHALL depend on state:
- IDLE/DONE: out_valid drops next cycle and the state goes to IDLE.
- REQ with req_ready=0 in the same cycle: abort to IDLE with no request.
- REQ with req_ready=1 same cycle, load: go to DRAIN.
- REQ with req_ready=1 same cycle, store: the request completes and the state goes to IDLE.
- WAIT: go to DRAIN.
REQ-023 In DRAIN, the FSM SHALL wait for rsp_valid, discard the data, and go to IDLE; in_allowin=0 in DRAIN.
REQ-024 A flush and a new in_valid in the same cycle SHALL leave the new input unaccepted.
REQ-025 rsp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-026 req_valid, once raised, SHALL stay high with stable req_* until req_ready, unless flushed.

Reset
REQ-027 On rst, the state SHALL be IDLE and all of the following SHALL be 0: out_valid, req_valid, req_we, req_wstrb, out_misalign, out_data, out_rd.
REQ-028 Reset mid-transaction SHALL abandon the transaction without DRAIN; the memory side is reset simultaneously.

Verification
REQ-029 XLEN=64 lb at addr 0x...03, memory word 0x0000_0000_80FF_0000 with 0x80 at byte 3 -> out_data=0xFFFF_FFFF_FFFF_FF80, latency 3.
REQ-030 sh data 0x1234 at addr 0x...06 -> req_wstrb=8'b1100_0000, req_wdata[63:48]=0x1234, req_we=1, no rsp wait, out_valid next cycle.
REQ-031 lw at addr 0x...02 -> out_misalign=1, req_valid never asserted, out_valid after 1 cycle.
REQ-032 load accepted, flush asserted in WAIT, rsp_valid 4 cycles later -> out_valid never asserted, in_allowin=1 the cycle after rsp.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_data/out_rd stable, in_allowin=0; stream of 4 ALU ops with out_ready=1 -> one result per cycle.
REQ-034 XLEN=32 lhu at addr 0x...02, word 0xABCD_0000 -> out_data=0x0000_ABCD.
